// File: rtl/msrv32_trap_ctrl_if.sv
// Decoder / CSR-file side bundle for the machine-mode trap sequencer.
// master = decode + CSR file, which drive the fields; slave = the trap controller.
interface msrv32_trap_ctrl_if;
  logic [4:0] opcode_6_to_2_in;
  logic [2:0] funct3_in;
  logic [6:0] funct7_in;
  logic [4:0] rs1_addr_in;
  logic [4:0] rs2_addr_in;
  logic [4:0] rd_addr_in;
  logic       illegal_instr_in;
  logic       misaligned_instr_in;
  logic       misaligned_load_in;
  logic       misaligned_store_in;
  logic       mie_in;
  logic       meie_in;
  logic       mtie_in;
  logic       msie_in;
  logic       meip_in;
  logic       mtip_in;
  logic       msip_in;
  logic       i_or_e_out;
  logic [3:0] cause_out;
  logic       set_cause_out;
  logic       set_epc_out;
  logic       mie_clear_out;
  logic       mie_set_out;
  logic       instret_inc_out;
  logic       misaligned_exception_out;
  logic [1:0] pc_src_out;
  logic       flush_out;

  modport master (
    output opcode_6_to_2_in, funct3_in, funct7_in, rs1_addr_in, rs2_addr_in, rd_addr_in,
           illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in,
           mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
    input  i_or_e_out, cause_out, set_cause_out, set_epc_out, mie_clear_out, mie_set_out,
           instret_inc_out, misaligned_exception_out, pc_src_out, flush_out
  );

  modport slave (
    input  opcode_6_to_2_in, funct3_in, funct7_in, rs1_addr_in, rs2_addr_in, rd_addr_in,
           illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in,
           mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
    output i_or_e_out, cause_out, set_cause_out, set_epc_out, mie_clear_out, mie_set_out,
           instret_inc_out, misaligned_exception_out, pc_src_out, flush_out
  );
endinterface

// File: rtl/msrv32_trap_ctrl.sv
// Machine-mode trap/interrupt sequencer: picks exception/interrupt cause, strobes the
// CSR file and steers fetch through BOOT / OPERATING / TRAP_TAKEN / TRAP_RETURN.
module msrv32_trap_ctrl #(
  parameter int BOOT_CYCLES = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  msrv32_trap_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    BOOT        = 2'b00,
    OPERATING   = 2'b01,
    TRAP_TAKEN  = 2'b10,
    TRAP_RETURN = 2'b11
  } state_e;

  localparam int              CNT_W     = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

  localparam logic [1:0] PC_BOOT = 2'b00;
  localparam logic [1:0] PC_EPC  = 2'b01;
  localparam logic [1:0] PC_TRAP = 2'b10;
  localparam logic [1:0] PC_NEXT = 2'b11;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic [3:0]       cause_q, cause_d;
  logic             i_or_e_q, i_or_e_d;

  // SYSTEM-opcode decode shared by ECALL/EBREAK/MRET
  logic sys_base, is_ecall, is_ebreak, is_mret;
  assign sys_base  = (bus.opcode_6_to_2_in == 5'b11100) && (bus.funct3_in == 3'b000) &&
                     (bus.rs1_addr_in == 5'd0) && (bus.rd_addr_in == 5'd0);
  assign is_ecall  = sys_base && (bus.funct7_in == 7'd0)       && (bus.rs2_addr_in == 5'd0);
  assign is_ebreak = sys_base && (bus.funct7_in == 7'd0)       && (bus.rs2_addr_in == 5'd1);
  assign is_mret   = sys_base && (bus.funct7_in == 7'b0011000) && (bus.rs2_addr_in == 5'b00010);

  logic mis_any, exc, irq;
  assign mis_any = bus.misaligned_instr_in | bus.misaligned_load_in | bus.misaligned_store_in;
  assign exc     = bus.illegal_instr_in | mis_any | is_ecall | is_ebreak;
  assign irq     = bus.mie_in & ((bus.meie_in & bus.meip_in) |
                                 (bus.msie_in & bus.msip_in) |
                                 (bus.mtie_in & bus.mtip_in));

  logic [3:0] exc_cause, irq_cause;

  always_comb begin
    exc_cause = 4'd11;
    if      (bus.misaligned_instr_in) exc_cause = 4'd0;
    else if (bus.illegal_instr_in)    exc_cause = 4'd2;
    else if (is_ebreak)               exc_cause = 4'd3;
    else if (bus.misaligned_load_in)  exc_cause = 4'd4;
    else if (bus.misaligned_store_in) exc_cause = 4'd6;
  end

  always_comb begin
    irq_cause = 4'd7;
    if      (bus.meie_in & bus.meip_in) irq_cause = 4'd11;
    else if (bus.msie_in & bus.msip_in) irq_cause = 4'd3;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= BOOT;
      boot_cnt_q <= '0;
      cause_q    <= 4'd0;
      i_or_e_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      cause_q    <= cause_d;
      i_or_e_q   <= i_or_e_d;
    end
  end

  always_comb begin
    state_d                      = state_q;
    boot_cnt_d                   = boot_cnt_q;
    cause_d                      = cause_q;
    i_or_e_d                     = i_or_e_q;
    bus.set_cause_out            = 1'b0;
    bus.set_epc_out              = 1'b0;
    bus.mie_clear_out            = 1'b0;
    bus.mie_set_out              = 1'b0;
    bus.instret_inc_out          = 1'b0;
    bus.misaligned_exception_out = 1'b0;
    bus.pc_src_out               = PC_BOOT;
    bus.flush_out                = 1'b1;

    case (state_q)
      BOOT: begin
        if (boot_cnt_q == BOOT_LAST) state_d    = OPERATING;
        else                         boot_cnt_d = boot_cnt_q + 1'b1;
      end
      OPERATING: begin
        bus.pc_src_out               = PC_NEXT;
        bus.flush_out                = 1'b0;
        bus.instret_inc_out          = ~(exc | irq);
        bus.misaligned_exception_out = mis_any;
        // exceptions win over a simultaneous interrupt
        if (exc) begin
          cause_d  = exc_cause;
          i_or_e_d = 1'b0;
          state_d  = TRAP_TAKEN;
        end else if (irq) begin
          cause_d  = irq_cause;
          i_or_e_d = 1'b1;
          state_d  = TRAP_TAKEN;
        end else if (is_mret) begin
          state_d  = TRAP_RETURN;
        end
      end
      TRAP_TAKEN: begin
        bus.set_cause_out = 1'b1;
        bus.set_epc_out   = 1'b1;
        bus.mie_clear_out = 1'b1;
        bus.pc_src_out    = PC_TRAP;
        state_d           = OPERATING;
      end
      TRAP_RETURN: begin
        bus.mie_set_out = 1'b1;
        bus.pc_src_out  = PC_EPC;
        state_d         = OPERATING;
      end
      default: state_d = BOOT;
    endcase
  end

  assign bus.cause_out  = cause_q;
  assign bus.i_or_e_out = i_or_e_q;

endmodule

// File: tb/tb_msrv32_trap_ctrl.sv
// Directed bench for msrv32_trap_ctrl: boot sequence, cause priority, interrupt
// masking, MRET return and reset during a trap.
module tb_msrv32_trap_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  msrv32_trap_ctrl_if bus ();
  msrv32_trap_ctrl #(.BOOT_CYCLES(2)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));

  task automatic clear_inputs();
    bus.opcode_6_to_2_in = 5'd0; bus.funct3_in = 3'd0; bus.funct7_in = 7'd0;
    bus.rs1_addr_in = 5'd0; bus.rs2_addr_in = 5'd0; bus.rd_addr_in = 5'd0;
    bus.illegal_instr_in = 1'b0; bus.misaligned_instr_in = 1'b0;
    bus.misaligned_load_in = 1'b0; bus.misaligned_store_in = 1'b0;
    bus.mie_in = 1'b0; bus.meie_in = 1'b0; bus.mtie_in = 1'b0; bus.msie_in = 1'b0;
    bus.meip_in = 1'b0; bus.mtip_in = 1'b0; bus.msip_in = 1'b0;
  endtask

  // kind: 0 none, 1 ECALL, 2 EBREAK, 3 MRET
  task automatic set_sys(input int kind);
    bus.opcode_6_to_2_in = (kind == 0) ? 5'b01100 : 5'b11100;
    bus.funct3_in = 3'd0; bus.rs1_addr_in = 5'd0; bus.rd_addr_in = 5'd0;
    bus.funct7_in   = (kind == 3) ? 7'b0011000 : 7'd0;
    bus.rs2_addr_in = (kind == 3) ? 5'b00010 : ((kind == 2) ? 5'd1 : 5'd0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (bus.pc_src_out !== 2'b00) begin errors++; $display("FAIL boot1_pc_src got %0d exp 0", bus.pc_src_out); end
    checks++; if (bus.flush_out !== 1'b1) begin errors++; $display("FAIL boot1_flush got %0b exp 1", bus.flush_out); end
    checks++; if (bus.cause_out !== 4'd0 || bus.i_or_e_out !== 1'b0) begin errors++; $display("FAIL rst_cause got %0d/%0b exp 0/0", bus.cause_out, bus.i_or_e_out); end
    checks++; if ({bus.set_cause_out, bus.set_epc_out, bus.mie_clear_out, bus.mie_set_out, bus.instret_inc_out} !== 5'b0) begin errors++; $display("FAIL boot_strobes got %b exp 00000", {bus.set_cause_out, bus.set_epc_out, bus.mie_clear_out, bus.mie_set_out, bus.instret_inc_out}); end
    tick();
    checks++; if (bus.pc_src_out !== 2'b00 || bus.flush_out !== 1'b1) begin errors++; $display("FAIL boot2 got pc=%0d flush=%0b exp pc=0 flush=1", bus.pc_src_out, bus.flush_out); end
    tick();
    checks++; if (bus.pc_src_out !== 2'b11 || bus.flush_out !== 1'b0) begin errors++; $display("FAIL operating got pc=%0d flush=%0b exp pc=3 flush=0", bus.pc_src_out, bus.flush_out); end
    checks++; if (bus.instret_inc_out !== 1'b1) begin errors++; $display("FAIL op_instret got %0b exp 1", bus.instret_inc_out); end
  endtask

  task automatic test_exc_illegal_load();
    bus.illegal_instr_in = 1'b1; bus.misaligned_load_in = 1'b1;
    #1;
    checks++; if (bus.instret_inc_out !== 1'b0 || bus.misaligned_exception_out !== 1'b1) begin errors++; $display("FAIL exc_pre got instret=%0b mis=%0b exp 0/1", bus.instret_inc_out, bus.misaligned_exception_out); end
    tick();
    checks++; if (bus.set_cause_out !== 1'b1 || bus.set_epc_out !== 1'b1 || bus.mie_clear_out !== 1'b1) begin errors++; $display("FAIL exc_strobes got %b%b%b exp 111", bus.set_cause_out, bus.set_epc_out, bus.mie_clear_out); end
    checks++; if (bus.cause_out !== 4'd2 || bus.i_or_e_out !== 1'b0) begin errors++; $display("FAIL exc_cause got %0d/%0b exp 2/0", bus.cause_out, bus.i_or_e_out); end
    checks++; if (bus.pc_src_out !== 2'b10 || bus.flush_out !== 1'b1 || bus.instret_inc_out !== 1'b0) begin errors++; $display("FAIL exc_pc got pc=%0d flush=%0b instret=%0b exp 2/1/0", bus.pc_src_out, bus.flush_out, bus.instret_inc_out); end
    checks++; if (bus.misaligned_exception_out !== 1'b0) begin errors++; $display("FAIL exc_mis_in_trap got %0b exp 0", bus.misaligned_exception_out); end
    clear_inputs();
    tick();
    checks++; if (bus.set_cause_out !== 1'b0 || bus.pc_src_out !== 2'b11) begin errors++; $display("FAIL exc_one_cycle got set_cause=%0b pc=%0d exp 0/3", bus.set_cause_out, bus.pc_src_out); end
    checks++; if (bus.cause_out !== 4'd2) begin errors++; $display("FAIL exc_cause_hold got %0d exp 2", bus.cause_out); end
  endtask

  task automatic test_exc_priority();
    // columns: mis_instr illegal mis_load mis_store sys_kind irq_mei expected_cause
    logic [3:0] exp_cause [8] = '{4'd0, 4'd3, 4'd4, 4'd6, 4'd11, 4'd3, 4'd11, 4'd6};
    logic [3:0] flags     [8] = '{4'b1111, 4'b0010, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    int         kind      [8] = '{2, 2, 0, 1, 1, 2, 1, 0};
    logic       mei       [8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    for (int i = 0; i < 8; i++) begin
      set_sys(kind[i]);
      {bus.misaligned_instr_in, bus.illegal_instr_in, bus.misaligned_load_in, bus.misaligned_store_in} = flags[i];
      bus.mie_in = mei[i]; bus.meie_in = mei[i]; bus.meip_in = mei[i];
      tick();
      checks++; if (bus.set_cause_out !== 1'b1 || bus.cause_out !== exp_cause[i] || bus.i_or_e_out !== 1'b0) begin errors++; $display("FAIL exc_prio[%0d] got set=%0b cause=%0d ie=%0b exp 1/%0d/0", i, bus.set_cause_out, bus.cause_out, bus.i_or_e_out, exp_cause[i]); end
      clear_inputs();
      tick();
    end
  endtask

  task automatic test_irq();
    logic [2:0] en  [4] = '{3'b101, 3'b011, 3'b001, 3'b111}; // {meie/meip, msie/msip, mtie/mtip}
    logic [3:0] exp [4] = '{4'd11, 4'd3, 4'd7, 4'd11};
    for (int i = 0; i < 4; i++) begin
      bus.mie_in = 1'b1;
      {bus.meie_in, bus.msie_in, bus.mtie_in} = en[i];
      {bus.meip_in, bus.msip_in, bus.mtip_in} = en[i];
      #1;
      checks++; if (bus.instret_inc_out !== 1'b0) begin errors++; $display("FAIL irq_instret[%0d] got %0b exp 0", i, bus.instret_inc_out); end
      tick();
      checks++; if (bus.set_cause_out !== 1'b1 || bus.mie_clear_out !== 1'b1 || bus.cause_out !== exp[i] || bus.i_or_e_out !== 1'b1) begin errors++; $display("FAIL irq[%0d] got set=%0b clr=%0b cause=%0d ie=%0b exp 1/1/%0d/1", i, bus.set_cause_out, bus.mie_clear_out, bus.cause_out, bus.i_or_e_out, exp[i]); end
      clear_inputs();
      tick();
    end
    // pending without its enable must not trap
    bus.mie_in = 1'b1; bus.meip_in = 1'b1; bus.msip_in = 1'b1; bus.mtie_in = 1'b1;
    tick();
    checks++; if (bus.set_cause_out !== 1'b0 || bus.instret_inc_out !== 1'b1) begin errors++; $display("FAIL irq_not_enabled got set=%0b instret=%0b exp 0/1", bus.set_cause_out, bus.instret_inc_out); end
    clear_inputs();
  endtask

  task automatic test_irq_masked();
    bus.mie_in = 1'b0;
    bus.meie_in = 1'b1; bus.mtie_in = 1'b1; bus.msie_in = 1'b1;
    bus.meip_in = 1'b1; bus.mtip_in = 1'b1; bus.msip_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.instret_inc_out !== 1'b1 || bus.set_cause_out !== 1'b0 || bus.pc_src_out !== 2'b11) begin errors++; $display("FAIL irq_masked[%0d] got instret=%0b set=%0b pc=%0d exp 1/0/3", i, bus.instret_inc_out, bus.set_cause_out, bus.pc_src_out); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_mret();
    set_sys(3);
    #1;
    checks++; if (bus.instret_inc_out !== 1'b1) begin errors++; $display("FAIL mret_instret got %0b exp 1", bus.instret_inc_out); end
    tick();
    checks++; if (bus.mie_set_out !== 1'b1 || bus.pc_src_out !== 2'b01 || bus.flush_out !== 1'b1 || bus.set_cause_out !== 1'b0) begin errors++; $display("FAIL mret got set=%0b pc=%0d flush=%0b cause_set=%0b exp 1/1/1/0", bus.mie_set_out, bus.pc_src_out, bus.flush_out, bus.set_cause_out); end
    clear_inputs();
    tick();
    checks++; if (bus.mie_set_out !== 1'b0 || bus.pc_src_out !== 2'b11) begin errors++; $display("FAIL mret_after got set=%0b pc=%0d exp 0/3", bus.mie_set_out, bus.pc_src_out); end
  endtask

  task automatic test_reset_in_trap();
    set_sys(1);
    tick();
    checks++; if (bus.set_cause_out !== 1'b1 || bus.cause_out !== 4'd11) begin errors++; $display("FAIL rtrap_enter got set=%0b cause=%0d exp 1/11", bus.set_cause_out, bus.cause_out); end
    clear_inputs();
    rst = 1'b1;
    tick();
    checks++; if ({bus.set_cause_out, bus.set_epc_out, bus.mie_clear_out, bus.mie_set_out} !== 4'b0 || bus.pc_src_out !== 2'b00 || bus.flush_out !== 1'b1) begin errors++; $display("FAIL rtrap_boot got strobes=%b pc=%0d flush=%0b exp 0000/0/1", {bus.set_cause_out, bus.set_epc_out, bus.mie_clear_out, bus.mie_set_out}, bus.pc_src_out, bus.flush_out); end
    checks++; if (bus.cause_out !== 4'd0 || bus.i_or_e_out !== 1'b0) begin errors++; $display("FAIL rtrap_cause got %0d/%0b exp 0/0", bus.cause_out, bus.i_or_e_out); end
    rst = 1'b0;
    bus.misaligned_instr_in = 1'b1;
    #1;
    checks++; if (bus.misaligned_exception_out !== 1'b0) begin errors++; $display("FAIL boot_mis got %0b exp 0", bus.misaligned_exception_out); end
    tick();
    clear_inputs();
    checks++; if (bus.pc_src_out !== 2'b00) begin errors++; $display("FAIL rtrap_boot2 got pc=%0d exp 0", bus.pc_src_out); end
    tick();
    checks++; if (bus.pc_src_out !== 2'b11 || bus.set_cause_out !== 1'b0) begin errors++; $display("FAIL rtrap_operating got pc=%0d set=%0b exp 3/0", bus.pc_src_out, bus.set_cause_out); end
  endtask

  initial begin
    test_reset();
    test_exc_illegal_load();
    test_exc_priority();
    test_irq();
    test_irq_masked();
    test_mret();
    test_reset_in_trap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
